alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised successor to the team's 8-bit combinational ALU. It adds registered outputs, a valid/ready handshake on input and output, and a stored carry flag for multi-word ADC/SBB chains. It also adds rotate, arithmetic-shift and compare ops, plus an optional iterative multiplier. It sits between the operand-fetch stage and writeback in the datapath, one op in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  op presented on A/B/ALU_Sel
in_ready  out  1  block can accept an op this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
ALU_Sel  in  4  opcode
out_valid  out  1  Result/flags valid
out_ready  in  1  consumer takes result this cycle
Result  out  WIDTH  registered result
Carry  out  1  carry/borrow/shifted-out bit
Zero  out  1  result (or CMP difference) == 0
Overflow  out  1  signed overflow
Negative  out  1  MSB of result (or CMP difference)
Illegal  out  1  opcode not supported

Behaviour:
- Reset: every output register, including Result and all flags, is 0. out_valid=0. The stored carry CF is 0. FSM goes to IDLE. in_ready=1 in the first cycle after reset.
- Reset while MUL is BUSY aborts the op. Nothing is emitted.
- Acceptance: in_valid & in_ready at a rising edge.
- Output holds Result/flags stable while out_valid & !out_ready. out_valid clears on out_valid & out_ready unless a new result is loaded on the same edge.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Back-to-back ops at full throughput are allowed.
- FSM states:
  - IDLE: a non-MUL op is loaded into the output regs on the acceptance edge; out_valid=1 the next cycle (latency 1). An accepted MUL goes to BUSY.
  - BUSY: WIDTH shift-add iterations, one per cycle. in_ready=0. Result loaded with out_valid=1 WIDTH cycles after acceptance. Return to IDLE.
- Opcodes, with width-WIDTH arithmetic and an internal WIDTH+1 sum:
  - 0000 ADD: A+B. Carry=bit WIDTH. Overflow = ~(A^B)&(A^R) at MSB.
  - 0001 SUB: A-B. Carry=borrow (bit WIDTH). Overflow = (A^B)&(A^R) at MSB.
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A: Carry=0, Overflow=0.
  - 0110 SHL1: Carry=A[MSB]. 0111 SHR1 (logical): Carry=A[0].
  - 1000 ADC: A+B+CF, flags as ADD.
  - 1001 SBB: A-B-CF, flags as SUB.
  - 1010 ASR1: MSB replicated. Carry=A[0].
  - 1011 ROL1: Carry=A[MSB]. 1100 ROR1: Carry=A[0].
  - 1101 CMP: Result=A unchanged. Carry/Zero/Overflow/Negative come from A-B.
  - 1110 MUL: Result = low WIDTH bits of the unsigned product. Carry = high half nonzero. Overflow=0.
  - 1111: Result=0, Illegal=1, all other flags 0.
- Zero = (Result==0), except for CMP. Negative = Result[MSB], except for CMP.
- CF is updated with Carry on every result load, including logic ops (which load 0). Illegal ops leave CF unchanged.
- Illegal=0 for all legal ops.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 1110 is the iterative multiply with the BUSY state, as above.
- Undefined: the BUSY state and multiplier logic are absent. Opcode 1110 behaves like 1111: Result=0, Illegal=1, latency 1, CF unchanged.

Test Plan:
- WIDTH=8, after reset: all outputs 0, in_ready=1. ADD A=0x7F B=0x01 -> Result=0x80, Overflow=1, Negative=1, Carry=0, out_valid high 1 cycle after accept.
- Multi-word add: ADD A=0xFF B=0x01 -> Result=0x00, Carry=1, Zero=1. Then ADC A=0x00 B=0x00 -> Result=0x01, Carry=0.
- SUB A=0x00 B=0x01 -> Result=0xFF, Carry=1. Then SBB A=0x05 B=0x02 -> Result=0x02. CMP A=0x10 B=0x10 -> Result=0x10, Zero=1.
- Shifts and rotates: ASR1 A=0x81 -> 0xC0, Carry=1. ROR1 A=0x01 -> 0x80, Carry=1. ROL1 A=0x80 -> 0x01, Carry=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> Result/flags stable, in_ready=0, no op lost or duplicated. Then out_ready=1 -> streaming with one result per cycle.
- With ALU_MUL_EN, MUL A=0x10 B=0x20 -> Result=0x00, Carry=1, out_valid 8 cycles after accept. Assert rst mid-BUSY -> no output, in_ready=1 after reset. Without ALU_MUL_EN, opcode 1110 -> Illegal=1, Result=0.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and a stored carry flag for ADC/SBB chains.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 1110) and its BUSY state.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow,
  output logic             Negative,
  output logic             Illegal
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL1 = 4'b0110;
  localparam logic [3:0] OP_SHR1 = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_SBB  = 4'b1001;
  localparam logic [3:0] OP_ASR1 = 4'b1010;
  localparam logic [3:0] OP_ROL1 = 4'b1011;
  localparam logic [3:0] OP_ROR1 = 4'b1100;
  localparam logic [3:0] OP_CMP  = 4'b1101;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1110;
`endif

  // Handshake: an op transfers in on a rising edge with in_valid & in_ready; a result
  // transfers out on a rising edge with out_valid & out_ready. Result/flags are held
  // stable while out_valid & !out_ready, and neither valid depends on its ready.

  logic             cf;
  logic             accept;
  logic             idle;
  logic             load_alu;
  logic [WIDTH:0]   cf_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] flag_src;
  logic             alu_c;
  logic             alu_v;
  logic             alu_z;
  logic             alu_n;
  logic             alu_ill;

  assign accept   = in_valid & in_ready;
  assign in_ready = idle & (~out_valid | out_ready);
  assign cf_ext   = {{WIDTH{1'b0}}, cf};

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        sum     = {1'b0, A} + {1'b0, B};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ alu_res[MSB]);
      end
      OP_SUB: begin
        sum     = {1'b0, A} - {1'b0, B};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[MSB] ^ B[MSB]) & (A[MSB] ^ alu_res[MSB]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      OP_SHL1: begin
        alu_res = {A[WIDTH-2:0], 1'b0};
        alu_c   = A[MSB];
      end
      OP_SHR1: begin
        alu_res = {1'b0, A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      OP_ADC: begin
        sum     = {1'b0, A} + {1'b0, B} + cf_ext;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ alu_res[MSB]);
      end
      OP_SBB: begin
        // The WIDTH+1 wrap leaves bit WIDTH set exactly when A < B + CF.
        sum     = {1'b0, A} - {1'b0, B} - cf_ext;
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[MSB] ^ B[MSB]) & (A[MSB] ^ alu_res[MSB]);
      end
      OP_ASR1: begin
        alu_res = {A[MSB], A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      OP_ROL1: begin
        alu_res = {A[WIDTH-2:0], A[MSB]};
        alu_c   = A[MSB];
      end
      OP_ROR1: begin
        alu_res = {A[0], A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      OP_CMP: begin
        sum     = {1'b0, A} - {1'b0, B};
        alu_res = A;
        alu_c   = sum[WIDTH];
        alu_v   = (A[MSB] ^ sum[MSB]) & (A[MSB] ^ B[MSB]);
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // CMP reports Zero/Negative on the difference while passing A through as Result.
  always_comb begin
    flag_src = (ALU_Sel == OP_CMP) ? sum[WIDTH-1:0] : alu_res;
    alu_z    = ~alu_ill & (flag_src == '0);
    alu_n    = ~alu_ill & flag_src[MSB];
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 start_mul;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;

  assign start_mul = accept & (ALU_Sel == OP_MUL);
  assign load_alu  = accept & (ALU_Sel != OP_MUL);
  assign idle      = (state == IDLE);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mul_done   = 1'b0;
    case (state)
      IDLE: if (start_mul) state_next = BUSY;
      BUSY: begin
        if (cnt == LAST_ITER) begin
          state_next = IDLE;
          mul_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One partial product per BUSY cycle; the final one is folded in on the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start_mul) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign idle     = 1'b1;
  assign load_alu = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Carry     <= 1'b0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Negative  <= 1'b0;
      Illegal   <= 1'b0;
      cf        <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      Result    <= alu_res;
      Carry     <= alu_c;
      Zero      <= alu_z;
      Overflow  <= alu_v;
      Negative  <= alu_n;
      Illegal   <= alu_ill;
      if (!alu_ill) cf <= alu_c;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out_valid <= 1'b1;
      Result    <= acc_next[WIDTH-1:0];
      Carry     <= |acc_next[2*WIDTH-1:WIDTH];
      Zero      <= (acc_next[WIDTH-1:0] == '0);
      Overflow  <= 1'b0;
      Negative  <= acc_next[MSB];
      Illegal   <= 1'b0;
      cf        <= |acc_next[2*WIDTH-1:WIDTH];
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: flags, carry chaining, illegal ops,
// backpressure streaming, and the multiplier path when ALU_MUL_EN is defined.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Carry;
  logic         Zero;
  logic         Overflow;
  logic         Negative;
  logic         Illegal;

  int n_pass  = 0;
  int n_total = 0;

  logic [12:0] exp_q[$];

  logic [3:0]  s_sel[6];
  logic [7:0]  s_a[6];
  logic [7:0]  s_b[6];
  logic [12:0] s_exp[6];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Carry     (Carry),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .Negative  (Negative),
    .Illegal   (Illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs();
    return {18'd0, out_valid, Result, Carry, Zero, Overflow, Negative, Illegal};
  endfunction

  function automatic logic [31:0] want(input logic [7:0] r, input logic [4:0] f);
    return {18'd0, 1'b1, r, f};
  endfunction

  task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_timeout", {31'd0, in_ready}, 32'd1);
    ALU_Sel  = sel;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // flags argument order: Carry, Zero, Overflow, Negative, Illegal
  task automatic alu(input string tag, input logic [3:0] sel, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] r, input logic [4:0] f);
    issue(sel, a, b);
    @(negedge clk);
    chk(tag, obs(), want(r, f));
  endtask

  task automatic wait_out(input string tag, output int lat, output logic rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      rdy_seen |= in_ready;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    int          pops;
    int          hold_n;
    int          first_pop;
    int          last_pop;
    int          lat;
    logic        acc_now;
    logic        seen;
    logic        rdy_seen;
    logic [12:0] e;

    s_sel[0] = 4'h0; s_a[0] = 8'h01; s_b[0] = 8'h02; s_exp[0] = {8'h03, 5'b00000};
    s_sel[1] = 4'h4; s_a[1] = 8'hAA; s_b[1] = 8'h0F; s_exp[1] = {8'hA5, 5'b00010};
    s_sel[2] = 4'h1; s_a[2] = 8'h10; s_b[2] = 8'h01; s_exp[2] = {8'h0F, 5'b00000};
    s_sel[3] = 4'h3; s_a[3] = 8'h00; s_b[3] = 8'h00; s_exp[3] = {8'h00, 5'b01000};
    s_sel[4] = 4'h0; s_a[4] = 8'h40; s_b[4] = 8'h40; s_exp[4] = {8'h80, 5'b00110};
    s_sel[5] = 4'h5; s_a[5] = 8'h00; s_b[5] = 8'h00; s_exp[5] = {8'hFF, 5'b00010};

    // clock/reset
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    ALU_Sel   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {18'd0, out_valid, Result, Carry, Zero, Overflow, Negative, Illegal}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // first op: latency 1 and single-cycle out_valid with out_ready high
    alu("add_ovf", 4'h0, 8'h7F, 8'h01, 8'h80, 5'b00110);
    @(negedge clk);
    chk("add_valid_drop", {31'd0, out_valid}, 32'd0);

    alu("add_carry",   4'h0, 8'hFF, 8'h01, 8'h00, 5'b11000);
    alu("adc_chain",   4'h8, 8'h00, 8'h00, 8'h01, 5'b00000);
    alu("sub_borrow",  4'h1, 8'h00, 8'h01, 8'hFF, 5'b10010);
    alu("sbb_chain",   4'h9, 8'h05, 8'h02, 8'h02, 5'b00000);
    alu("cmp_equal",   4'hD, 8'h10, 8'h10, 8'h10, 5'b01000);
    alu("cmp_less",    4'hD, 8'h00, 8'h01, 8'h00, 5'b10010);
    alu("asr1",        4'hA, 8'h81, 8'h00, 8'hC0, 5'b10010);
    alu("ror1",        4'hC, 8'h01, 8'h00, 8'h80, 5'b10010);
    alu("rol1",        4'hB, 8'h80, 8'h00, 8'h01, 5'b10000);
    alu("illegal",     4'hF, 8'h12, 8'h34, 8'h00, 5'b00001);
    alu("adc_keep_cf", 4'h8, 8'h00, 8'h00, 8'h01, 5'b00000);
    alu("sub_ovf",     4'h1, 8'h80, 8'h01, 8'h7F, 5'b00100);
    alu("and",         4'h2, 8'hF0, 8'h3C, 8'h30, 5'b00000);
    alu("or_zero",     4'h3, 8'h00, 8'h00, 8'h00, 5'b01000);
    alu("xor",         4'h4, 8'h0F, 8'hFF, 8'hF0, 5'b00010);
    alu("not",         4'h5, 8'h55, 8'h00, 8'hAA, 5'b00010);
    alu("shl1",        4'h6, 8'h81, 8'h00, 8'h02, 5'b10000);
    alu("shr1",        4'h7, 8'h81, 8'h00, 8'h40, 5'b10000);
    alu("and_clr_cf",  4'h2, 8'hFF, 8'hFF, 8'hFF, 5'b00010);
    alu("adc_cf_zero", 4'h8, 8'h00, 8'h00, 8'h00, 5'b01000);
    alu("shl1_set_cf", 4'h6, 8'h81, 8'h00, 8'h02, 5'b10000);
    alu("adc_cf_ovf",  4'h8, 8'h7F, 8'h00, 8'h80, 5'b00110);

`ifdef ALU_MUL_EN
    issue(4'hE, 8'h10, 8'h20);
    wait_out("mul_timeout", lat, rdy_seen);
    chk("mul_latency", lat, 32'd8);
    chk("mul_busy_in_ready", {31'd0, rdy_seen}, 32'd0);
    chk("mul_result", obs(), want(8'h00, 5'b11000));

    issue(4'hE, 8'h0F, 8'h0F);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_output", {31'd0, seen}, 32'd0);

    issue(4'hE, 8'h0F, 8'h0F);
    wait_out("mul2_timeout", lat, rdy_seen);
    chk("mul_after_abort", obs(), want(8'hE1, 5'b00010));
`else
    alu("shl1_pre_mul",  4'h6, 8'h81, 8'h00, 8'h02, 5'b10000);
    alu("mul_disabled",  4'hE, 8'h10, 8'h20, 8'h00, 5'b00001);
    alu("adc_after_mul", 4'h8, 8'h00, 8'h00, 8'h01, 5'b00000);
`endif

    // backpressure then streaming
    @(negedge clk);
    out_ready = 1'b0;
    idx       = 0;
    ALU_Sel   = s_sel[0];
    A         = s_a[0];
    B         = s_b[0];
    in_valid  = 1'b1;
    pops      = 0;
    hold_n    = 0;
    first_pop = -1;
    last_pop  = -1;
    for (int cyc = 0; cyc < 40 && pops < 6; cyc++) begin
      if (out_valid && !out_ready) begin
        hold_n++;
        if (exp_q.size() > 0)
          chk("bp_hold_result", {19'd0, Result, Carry, Zero, Overflow, Negative, Illegal},
              {19'd0, exp_q[0]});
        else
          chk("bp_hold_spurious", {31'd0, out_valid}, 32'd0);
        chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bp_stream", {19'd0, Result, Carry, Zero, Overflow, Negative, Illegal}, {19'd0, e});
        end else begin
          chk("bp_spurious", {31'd0, out_valid}, 32'd0);
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      acc_now = in_valid && in_ready;
      if (acc_now) exp_q.push_back(s_exp[idx]);
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 6) begin
          ALU_Sel = s_sel[idx];
          A       = s_a[idx];
          B       = s_b[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (cyc >= 5);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_hold_cycles", hold_n, 32'd5);
    chk("bp_result_count", pops, 32'd6);
    chk("bp_queue_empty", exp_q.size(), 32'd0);
    chk("bp_stream_rate", last_pop - first_pop, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
